// File: rtl/cv32e40px_rvfi_trap_tracker.sv
// RVFI retirement record builder: packs trap/intr fields per retired instruction and queues them in a FIFO.
// Optional saturating drop counter enabled by defining CV32E40PX_RVFI_DROP_CNT_EN.
module cv32e40px_rvfi_trap_tracker #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ret_valid_i,
  input  logic [31:0] ret_pc_i,
  input  logic [31:0] ret_insn_i,
  input  logic        exc_valid_i,
  input  logic [5:0]  exc_cause_i,
  input  logic        irq_taken_i,
  input  logic [10:0] irq_id_i,
  input  logic        dbg_enter_i,
  input  logic [2:0]  dbg_cause_i,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic [31:0] rec_pc_o,
  output logic [31:0] rec_insn_o,
  output logic [13:0] rec_trap_o,
  output logic [13:0] rec_intr_o,
  output logic [63:0] rec_order_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = 156;

  typedef enum logic [1:0] {IDLE, PEND_EXC, PEND_IRQ} state_t;

  state_t        state_reg, state_next;
  logic [10:0]   cause_reg, cause_next;
  logic [63:0]   order_reg;
  logic [13:0]   trap_rec, intr_rec;
  logic [RW-1:0] rec_new, head;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, head_idx;
  logic [AW:0]   count_reg;
  logic          full, pop, push;

  always_comb begin
    trap_rec = {2'b00,
                dbg_enter_i ? dbg_cause_i : 3'd0,
                exc_valid_i ? exc_cause_i : 6'd0,
                dbg_enter_i, exc_valid_i, exc_valid_i | dbg_enter_i};
    case (state_reg)
      PEND_EXC: intr_rec = {cause_reg, 1'b0, 1'b1, 1'b1};
      PEND_IRQ: intr_rec = {cause_reg, 1'b1, 1'b0, 1'b1};
      default:  intr_rec = 14'd0;
    endcase
    rec_new = {ret_pc_i, ret_insn_i, trap_rec, intr_rec, order_reg};
  end

  // Priority: debug entry cancels, then interrupt beats a same-cycle exception.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    if (dbg_enter_i && ret_valid_i) begin
      state_next = IDLE;
      cause_next = 11'd0;
    end else if (irq_taken_i) begin
      state_next = PEND_IRQ;
      cause_next = irq_id_i;
    end else if (ret_valid_i && exc_valid_i) begin
      state_next = PEND_EXC;
      cause_next = {5'b0, exc_cause_i};
    end else if (ret_valid_i) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cause_reg <= 11'd0;
      order_reg <= 64'd0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (ret_valid_i) order_reg <= order_reg + 64'd1;
    end
  end

  assign full = (count_reg == (AW+1)'(DEPTH));
  assign pop  = (count_reg != '0) && rec_ready_i;
  assign push = ret_valid_i && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= rec_new;
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (AW+1)'(1);
    end
  end

  // When empty, show the entry just popped so the head holds its last value.
  assign head_idx    = (count_reg != '0) ? rd_ptr_reg : rd_ptr_reg - AW'(1);
  assign head        = mem[head_idx];
  assign rec_valid_o = (count_reg != '0);
  assign rec_pc_o    = head[155:124];
  assign rec_insn_o  = head[123:92];
  assign rec_trap_o  = head[91:78];
  assign rec_intr_o  = head[77:64];
  assign rec_order_o = head[63:0];

`ifdef CV32E40PX_RVFI_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_reg;

  assign drop = ret_valid_i && full && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                drop_cnt_reg <= 16'd0;
    else if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign drop_cnt_o = drop_cnt_reg;
`else
  assign drop_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_cv32e40px_rvfi_trap_tracker.sv
// Self-checking bench for cv32e40px_rvfi_trap_tracker: vector table plus multi-cycle sequences, scoreboard on output.
module tb_cv32e40px_rvfi_trap_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ret_valid_i = 1'b0;
  logic [31:0] ret_pc_i = '0;
  logic [31:0] ret_insn_i = '0;
  logic        exc_valid_i = 1'b0;
  logic [5:0]  exc_cause_i = '0;
  logic        irq_taken_i = 1'b0;
  logic [10:0] irq_id_i = '0;
  logic        dbg_enter_i = 1'b0;
  logic [2:0]  dbg_cause_i = '0;
  logic        rec_valid_o;
  logic        rec_ready_i = 1'b0;
  logic [31:0] rec_pc_o;
  logic [31:0] rec_insn_o;
  logic [13:0] rec_trap_o;
  logic [13:0] rec_intr_o;
  logic [63:0] rec_order_o;
  logic [15:0] drop_cnt_o;

  cv32e40px_rvfi_trap_tracker #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_insn_i(ret_insn_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .irq_taken_i(irq_taken_i), .irq_id_i(irq_id_i),
    .dbg_enter_i(dbg_enter_i), .dbg_cause_i(dbg_cause_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_pc_o(rec_pc_o), .rec_insn_o(rec_insn_o), .rec_trap_o(rec_trap_o),
    .rec_intr_o(rec_intr_o), .rec_order_o(rec_order_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ret;
    logic [31:0] pc;
    logic        exc;
    logic [5:0]  ec;
    logic        irq;
    logic [10:0] iid;
    logic        dbg;
    logic [2:0]  dc;
    logic [13:0] trap;
    logic [13:0] intr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [13:0] trap;
    logic [13:0] intr;
    logic [63:0] order;
  } rec_t;

  rec_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_order = 64'd0;
  vec_t        vecs[20];

  function automatic logic [13:0] mk_trap(logic [2:0] dc, logic [5:0] ec, logic dbg, logic exc, logic trap);
    return {2'b00, dc, ec, dbg, exc, trap};
  endfunction

  function automatic logic [13:0] mk_intr(logic [10:0] cause, logic irq, logic exc, logic intr);
    return {cause, irq, exc, intr};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Scoreboard consumer: every accepted head is compared to the oldest expected record.
  always @(negedge clk_i) begin
    if (!rst_i && rec_valid_o && rec_ready_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_record pc=%h order=%0d", rec_pc_o, rec_order_o);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if ({rec_pc_o, rec_insn_o, rec_trap_o, rec_intr_o, rec_order_o} !==
            {e.pc, e.insn, e.trap, e.intr, e.order}) begin
          tests_failed++;
          $display("FAIL record got pc=%h insn=%h trap=%h intr=%h order=%0d want pc=%h insn=%h trap=%h intr=%h order=%0d",
                   rec_pc_o, rec_insn_o, rec_trap_o, rec_intr_o, rec_order_o,
                   e.pc, e.insn, e.trap, e.intr, e.order);
        end else begin
          $display("[TB] rec pc=%h trap=%h intr=%h order=%0d ok", rec_pc_o, rec_trap_o, rec_intr_o, rec_order_o);
        end
      end
    end
  end

  task automatic drive(input vec_t v, input logic expect_rec);
    rec_t e;
    @(posedge clk_i); #1;
    ret_valid_i = v.ret; ret_pc_i = v.pc; ret_insn_i = ~v.pc;
    exc_valid_i = v.exc; exc_cause_i = v.ec;
    irq_taken_i = v.irq; irq_id_i = v.iid;
    dbg_enter_i = v.dbg; dbg_cause_i = v.dc;
    if (v.ret) begin
      e.pc = v.pc; e.insn = ~v.pc; e.trap = v.trap; e.intr = v.intr; e.order = exp_order;
      if (expect_rec) exp_q.push_back(e);
      exp_order = exp_order + 64'd1;
    end
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    ret_valid_i = 0; exc_valid_i = 0; irq_taken_i = 0; dbg_enter_i = 0;
  endtask

  function automatic vec_t plain(logic [31:0] pc);
    vec_t v;
    v = '{1'b1, pc, 1'b0, 6'd0, 1'b0, 11'd0, 1'b0, 3'd0, 14'd0, 14'd0};
    return v;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_i); n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ret_valid_i = 0; exc_valid_i = 0; irq_taken_i = 0; dbg_enter_i = 0;
    repeat (2) @(posedge clk_i);
    exp_q.delete();
    exp_order = 64'd0;
    #1 rst_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = plain(32'h100);
    vecs[1]  = plain(32'h104);
    vecs[2]  = plain(32'h108);
    vecs[3]  = '{1'b1, 32'h200, 1'b1, 6'd2, 1'b0, 11'd0, 1'b0, 3'd0, mk_trap(3'd0, 6'd2, 0, 1, 1), 14'd0};
    vecs[4]  = plain(32'h800); vecs[4].intr = mk_intr(11'd2, 0, 1, 1);
    vecs[5]  = plain(32'h804);
    vecs[6]  = '{1'b1, 32'h300, 1'b1, 6'd5, 1'b1, 11'd11, 1'b0, 3'd0, mk_trap(3'd0, 6'd5, 0, 1, 1), 14'd0};
    vecs[7]  = plain(32'h900); vecs[7].intr = mk_intr(11'd11, 1, 0, 1);
    vecs[8]  = '{1'b1, 32'h400, 1'b1, 6'd7, 1'b0, 11'd0, 1'b0, 3'd0, mk_trap(3'd0, 6'd7, 0, 1, 1), 14'd0};
    vecs[9]  = '{1'b1, 32'h500, 1'b0, 6'd0, 1'b0, 11'd0, 1'b1, 3'd3, mk_trap(3'd3, 6'd0, 1, 0, 1), mk_intr(11'd7, 0, 1, 1)};
    vecs[10] = plain(32'hA00);
    vecs[11] = '{1'b1, 32'h600, 1'b1, 6'd11, 1'b0, 11'd0, 1'b1, 3'd1, mk_trap(3'd1, 6'd11, 1, 1, 1), 14'd0};
    vecs[12] = plain(32'h604);
    vecs[13] = '{1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 11'd3, 1'b0, 3'd0, 14'd0, 14'd0};
    vecs[14] = plain(32'h700); vecs[14].intr = mk_intr(11'd3, 1, 0, 1);
    vecs[15] = '{1'b0, 32'h0, 1'b1, 6'd9, 1'b0, 11'd0, 1'b0, 3'd0, 14'd0, 14'd0};
    vecs[16] = plain(32'h704);
    vecs[17] = plain(32'h708); vecs[17].irq = 1'b1; vecs[17].iid = 11'd7;
    vecs[18] = '{1'b1, 32'h70C, 1'b1, 6'd4, 1'b0, 11'd0, 1'b0, 3'd0, mk_trap(3'd0, 6'd4, 0, 1, 1), mk_intr(11'd7, 1, 0, 1)};
    vecs[19] = plain(32'h710); vecs[19].intr = mk_intr(11'd4, 0, 1, 1);

    do_reset();
    @(negedge clk_i);
    check("reset_valid", 64'(rec_valid_o), 64'd0);
    check("reset_pc",    64'(rec_pc_o),    64'd0);
    check("reset_insn",  64'(rec_insn_o),  64'd0);
    check("reset_trap",  64'(rec_trap_o),  64'd0);
    check("reset_intr",  64'(rec_intr_o),  64'd0);
    check("reset_order", rec_order_o,      64'd0);
    check("reset_drop",  64'(drop_cnt_o),  64'd0);

    // Vector table, one retirement per cycle with the consumer always ready.
    rec_ready_i = 1'b1;
    drive(vecs[0], 1'b1);
    idle();
    @(negedge clk_i);
    check("latency_valid", 64'(rec_valid_o), 64'd1);
    for (int i = 1; i < 20; i++) drive(vecs[i], 1'b1);
    idle();
    wait_drain("table_drain");

    // Overflow: four entries held, two dropped, head stable while stalled.
    do_reset();
    rec_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) drive(plain(32'hC00 + 32'(4 * i)), i < 4);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("hold_valid", 64'(rec_valid_o), 64'd1);
      check("hold_pc",    64'(rec_pc_o),    64'h0C00);
    end
`ifdef CV32E40PX_RVFI_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt_o), 64'd2);
`else
    check("drop_cnt", 64'(drop_cnt_o), 64'd0);
`endif
    @(posedge clk_i); #1 rec_ready_i = 1'b1;
    wait_drain("overflow_drain");
    drive(plain(32'hD00), 1'b1);
    idle();
    wait_drain("after_drop_order");

    // Asynchronous reset with entries queued and an interrupt pending.
    rec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) drive(plain(32'hE00 + 32'(4 * i)), 1'b1);
    drive('{1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 11'd9, 1'b0, 3'd0, 14'd0, 14'd0}, 1'b0);
    idle();
    @(posedge clk_i); #1;
    check("pre_reset_valid", 64'(rec_valid_o), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_valid", 64'(rec_valid_o), 64'd0);
    check("async_reset_order", rec_order_o, 64'd0);
    exp_q.delete();
    exp_order = 64'd0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    rec_ready_i = 1'b1;
    drive(plain(32'hB00), 1'b1);
    idle();
    wait_drain("post_reset_record");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
